// File: rtl/rb_regfile_sb.sv
// rb_regfile_sb: write-back register bank with same-cycle bypass and a busy
// scoreboard for decode hazard stalls.
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_addr_a/b, out_RA/B combinational read ports (write-back bypassed)
//   wr_en/addr/data       write-back port; clears the destination busy bit
//   iss_en/addr           issue port; reserves (sets busy on) the destination
//   busy_a/b, stall       hazard outputs for decode (RAW on reads, WAW on issue)
//   pend_cnt              number of registers currently marked busy
module rb_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] out_RA,
  output logic [DATA_W-1:0] out_RB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = ADDR_W + 1;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy;

  logic zero_a, zero_b, zero_w, zero_i;
  logic wr_ok, hit_a, hit_b, hit_i, waw, iss_ok, inc, dec;

  // With ZR set, address 0 is hard-wired: it never bypasses, never goes busy.
  assign zero_a = ZR && (rd_addr_a == '0);
  assign zero_b = ZR && (rd_addr_b == '0);
  assign zero_w = ZR && (wr_addr   == '0);
  assign zero_i = ZR && (iss_addr  == '0);

  assign wr_ok = wr_en && !zero_w;
  assign hit_a = wr_ok && (wr_addr == rd_addr_a);
  assign hit_b = wr_ok && (wr_addr == rd_addr_b);
  assign hit_i = wr_ok && (wr_addr == iss_addr);

  assign out_RA = zero_a ? '0 : (hit_a ? wr_data : regs[rd_addr_a]);
  assign out_RB = zero_b ? '0 : (hit_b ? wr_data : regs[rd_addr_b]);

  // A write landing this cycle satisfies the pending producer.
  assign busy_a = busy[rd_addr_a] && !hit_a;
  assign busy_b = busy[rd_addr_b] && !hit_b;
  assign waw    = iss_en && busy[iss_addr] && !hit_i;
  assign stall  = busy_a || busy_b || waw;

  assign iss_ok = iss_en && !stall && !zero_i;

  // Counter tracks bit transitions: a same-register write+issue leaves the
  // bit set, so the write only counts as a clear when the issue does not
  // re-set the same bit.
  assign inc = iss_ok && !busy[iss_addr];
  assign dec = wr_ok && busy[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      // Issue after write: the new producer wins on a shared address.
      if (iss_ok) busy[iss_addr] <= 1'b1;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
    end
  end
endmodule

// File: tb/tb_rb_regfile_sb.sv
// Testbench for rb_regfile_sb: directed hazard scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_rb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
  logic [31:0] out_RA, out_RB, wr_data;
  logic        wr_en, iss_en, busy_a, busy_b, stall;
  logic [5:0]  pend_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model
  logic [31:0] m_reg [32];
  bit          m_busy[32];

  rb_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .out_RA(out_RA), .out_RB(out_RB),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_a(busy_a), .busy_b(busy_b), .stall(stall), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic bit m_rbusy(input logic [4:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a && a != 0);
  endfunction

  function automatic bit m_stall();
    bit waw;
    waw = iss_en && m_busy[iss_addr] && !(wr_en && wr_addr == iss_addr && iss_addr != 0);
    return m_rbusy(rd_addr_a) || m_rbusy(rd_addr_b) || waw;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ra"},    out_RA,           m_read(rd_addr_a));
    chk({tag, ".rb"},    out_RB,           m_read(rd_addr_b));
    chk({tag, ".busya"}, 32'(busy_a),      32'(m_rbusy(rd_addr_a)));
    chk({tag, ".busyb"}, 32'(busy_b),      32'(m_rbusy(rd_addr_b)));
    chk({tag, ".stall"}, 32'(stall),       32'(m_stall()));
    chk({tag, ".pend"},  32'(pend_cnt),    32'(m_count()));
  endtask

  // Drive at the falling edge, then check the combinational outputs.
  task automatic apply(input logic [4:0] ra, input logic [4:0] rb, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input string tag);
    @(negedge clk);
    rd_addr_a = ra; rd_addr_b = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    #1;
    check_all(tag);
  endtask

  // Take the rising edge and advance the model with the same inputs.
  task automatic commit();
    bit acc;
    acc = iss_en && !m_stall() && iss_addr != 0;
    @(posedge clk);
    if (wr_en && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (acc) m_busy[iss_addr] = 1'b1;
    #1;
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0;
    rd_addr_a = 5'd9; rd_addr_b = 5'd17;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    #2;
    chk("rst.ra",    out_RA, 32'h0);
    chk("rst.rb",    out_RB, 32'h0);
    chk("rst.stall", 32'({busy_a, busy_b, stall}), 32'h0);
    chk("rst.pend",  32'(pend_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read, and same-cycle bypass
    apply(5'd0, 5'd0, 1'b1, 5'd5, 32'hFFFF0000, 1'b0, 5'd0, "wr5");
    commit();
    apply(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, "rd5");
    chk("rd5.const", out_RB, 32'hFFFF0000);
    apply(5'd5, 5'd0, 1'b1, 5'd5, 32'h0000FFFF, 1'b0, 5'd0, "byp5");
    chk("byp5.const", out_RA, 32'h0000FFFF);
    commit();

    // RAW on R7
    apply(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, "iss7");
    commit();
    apply(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, "raw7");
    chk("raw7.const", 32'({busy_a, stall, pend_cnt}), 32'({1'b1, 1'b1, 6'd1}));
    apply(5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, "wb7");
    chk("wb7.const", 32'({busy_a, stall}), 32'h0);
    chk("wb7.data",  out_RA, 32'h12345678);
    commit();
    chk("wb7.pend", 32'(pend_cnt), 32'h0);

    // simultaneous issue+write to R3, then WAW re-issue
    apply(5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, "sim3");
    commit();
    chk("sim3.pend", 32'(pend_cnt), 32'h1);
    apply(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, "waw3");
    chk("waw3.stall", 32'(stall), 32'h1);
    commit();
    chk("waw3.pend", 32'(pend_cnt), 32'h1);
    apply(5'd3, 5'd0, 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, "clr3");
    commit();

    // zero register
    apply(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, "zero");
    chk("zero.const", 32'({out_RA, busy_a}), 32'h0);
    commit();
    apply(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, "zero2");
    chk("zero2.pend", 32'(pend_cnt), 32'h0);

    // async reset mid-operation
    apply(5'd0, 5'd0, 1'b1, 5'd1, 32'h55, 1'b1, 5'd1, "b1");
    commit();
    apply(5'd0, 5'd0, 1'b1, 5'd2, 32'h66, 1'b1, 5'd2, "b2");
    commit();
    chk("b12.pend", 32'(pend_cnt), 32'h2);
    @(negedge clk);
    rd_addr_a = 5'd1; rd_addr_b = 5'd2; wr_en = 1'b0; iss_en = 1'b0;
    #1;
    chk("pre.r1", out_RA, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.pend", 32'(pend_cnt), 32'h0);
    chk("arst.r1",   out_RA, 32'h0);
    chk("arst.r2",   out_RB, 32'h0);
    rst_n = 1'b1;
    m_reset();

    // random traffic, addresses focused on a few registers to force hazards
    for (int n = 0; n < 400; n++) begin
      apply(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), "rnd");
      commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
